// File: rtl/morse_timing_calibrator.sv
// Learns the Morse dit length from the shortest of SAMPLE_MARKS keyed marks and derives dah/word/tolerance timing.
// Optional macro MORSE_CAL_MANUAL_EN adds a manual dit override (use_manual, manual_dit).
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 12
`endif

module morse_timing_calibrator #(
   parameter int SAMPLE_MARKS = 8,
   parameter int MIN_PULSE    = 2,
   parameter int DEFAULT_DIT  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    signal,
   input  logic                    recal,
`ifdef MORSE_CAL_MANUAL_EN
   input  logic                    use_manual,
   input  logic [`PULSE_CNT_W-1:0] manual_dit,
`endif
   output logic [`PULSE_CNT_W-1:0] dit_time,
   output logic [`PULSE_CNT_W-1:0] dah_time,
   output logic [`PULSE_CNT_W-1:0] word_time,
   output logic [`PULSE_CNT_W-1:0] tol_time,
   output logic                    locked,
   output logic                    cal_error
);
   localparam int W = `PULSE_CNT_W;
   localparam logic [W-1:0] DEF_DIT  = W'(DEFAULT_DIT);
   localparam logic [W-1:0] DEF_DAH  = W'(3 * DEFAULT_DIT);
   localparam logic [W-1:0] DEF_WORD = W'(7 * DEFAULT_DIT);
   localparam logic [W-1:0] DEF_TOL  = W'(DEFAULT_DIT / 2);

   typedef enum logic [1:0] {IDLE, WAIT_LOW, MEASURE, LOCKED} state_t;

   state_t       state;
   logic         sig_q;
   logic [W-1:0] mark_cnt;
   logic [W-1:0] min_mark;
   logic [7:0]   acc_cnt;
   logic [7:0]   low_cnt;

   logic         rise, fall, mark_sat, accept, last_mark, ovf;
   logic [W-1:0] new_min, cal_src;
   logic [W+2:0] ext, prod3, prod7;

   always_comb begin
      rise      = signal & ~sig_q;
      fall      = ~signal & sig_q;
      mark_sat  = (mark_cnt == '1);
      accept    = fall && (mark_cnt >= W'(MIN_PULSE));
      last_mark = accept && (acc_cnt == 8'(SAMPLE_MARKS - 1));
      new_min   = (mark_cnt < min_mark) ? mark_cnt : min_mark;
      cal_src   = new_min;
`ifdef MORSE_CAL_MANUAL_EN
      if (use_manual)
         cal_src = manual_dit;
`endif
      ext   = {3'b000, cal_src};
      prod3 = ext + (ext << 1);
      prod7 = (ext << 3) - ext;
      ovf   = (|prod7[W+2:W]) | (|prod3[W+2:W]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_LOW;
         sig_q     <= 1'b0;
         mark_cnt  <= '0;
         min_mark  <= '1;
         acc_cnt   <= '0;
         low_cnt   <= '0;
         dit_time  <= DEF_DIT;
         dah_time  <= DEF_DAH;
         word_time <= DEF_WORD;
         tol_time  <= DEF_TOL;
         locked    <= 1'b0;
         cal_error <= 1'b0;
      end else begin
         cal_error <= 1'b0;
`ifdef MORSE_CAL_MANUAL_EN
         if (use_manual) begin
            state    <= WAIT_LOW;
            locked   <= 1'b1;
            acc_cnt  <= '0;
            mark_cnt <= '0;
            low_cnt  <= '0;
            if (ovf) begin
               cal_error <= 1'b1;
            end else begin
               dit_time  <= cal_src;
               dah_time  <= prod3[W-1:0];
               word_time <= prod7[W-1:0];
               tol_time  <= {1'b0, cal_src[W-1:1]};
            end
         end else
`endif
         if (recal) begin
            state    <= WAIT_LOW;
            locked   <= 1'b0;
            acc_cnt  <= '0;
            mark_cnt <= '0;
            low_cnt  <= '0;
         end else if (ce) begin
            sig_q <= signal;
            case (state)
               WAIT_LOW: begin
                  locked <= 1'b0;
                  if (!signal) begin
                     state    <= MEASURE;
                     min_mark <= '1;
                     acc_cnt  <= '0;
                     mark_cnt <= '0;
                  end
               end
               MEASURE: begin
                  locked <= 1'b0;
                  if (mark_sat) begin
                     // A stuck key cannot be a dit; give up and wait for the line to drop.
                     cal_error <= 1'b1;
                     state     <= WAIT_LOW;
                     acc_cnt   <= '0;
                     mark_cnt  <= '0;
                  end else if (rise) begin
                     mark_cnt <= W'(1);
                  end else if (signal) begin
                     mark_cnt <= mark_cnt + W'(1);
                  end else if (accept) begin
                     if (!last_mark) begin
                        acc_cnt  <= acc_cnt + 8'd1;
                        min_mark <= new_min;
                     end else if (ovf) begin
                        cal_error <= 1'b1;
                        state     <= WAIT_LOW;
                        acc_cnt   <= '0;
                     end else begin
                        dit_time  <= cal_src;
                        dah_time  <= prod3[W-1:0];
                        word_time <= prod7[W-1:0];
                        tol_time  <= {1'b0, cal_src[W-1:1]};
                        locked    <= 1'b1;
                        state     <= LOCKED;
                        acc_cnt   <= '0;
                        low_cnt   <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (signal) begin
                     low_cnt <= '0;
                  end else if (low_cnt == 8'd254) begin
                     state   <= IDLE;
                     low_cnt <= '0;
                  end else begin
                     low_cnt <= low_cnt + 8'd1;
                  end
               end
               IDLE: begin
                  if (signal) begin
                     state   <= LOCKED;
                     low_cnt <= '0;
                  end
               end
               default: state <= WAIT_LOW;
            endcase
         end
      end
   end
endmodule

// File: doc/morse_timing_calibrator.md
MORSE_TIMING_CALIBRATOR -- requirements
Module: morse_timing_calibrator

Interface
REQ-001 SHALL have parameter SAMPLE_MARKS, default 8: accepted marks per calibration, range 2..255.
REQ-002 SHALL have parameter MIN_PULSE, default 2: marks shorter than this many ce ticks are glitches.
REQ-003 SHALL have parameter DEFAULT_DIT, default 10: dit estimate loaded at reset.
REQ-004 SHALL have port clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ce  in  1  timing tick; signal is sampled and counters advance only when ce=1.
REQ-007 SHALL have port signal  in  1  keyed input, 1=mark; same net that feeds the capture/decode path.
REQ-008 SHALL have port recal  in  1  one-cycle request to restart calibration; sampled regardless of ce.
REQ-009 SHALL have outputs dit_time, dah_time, word_time, tol_time  out  `PULSE_CNT_W each: timing configuration for the capture/decode path.
REQ-010 SHALL have port locked  out  1  high while the outputs come from a completed calibration.
REQ-011 SHALL have port cal_error  out  1  one-cycle pulse on a failed calibration.

Function
REQ-012 SHALL implement states IDLE, WAIT_LOW, MEASURE and LOCKED; after reset the state is WAIT_LOW.
REQ-013 WAIT_LOW SHALL go to MEASURE on the first ce cycle with signal=0, so a partially seen mark is never measured.
REQ-014 In MEASURE, a mark counter SHALL clear on a ce-qualified rising edge of signal and increment on each ce cycle with signal=1, saturating at all-ones.
REQ-015 A mark SHALL end on a ce cycle with previous sampled signal=1 and current signal=0.
REQ-016 A mark shorter than MIN_PULSE SHALL be ignored: no count change and no min update.
REQ-017 A saturated mark SHALL abort calibration: cal_error pulses, the previous outputs are kept, and the state goes to WAIT_LOW.
REQ-018 Each accepted mark SHALL increment an accepted-mark count and update min_mark = min(min_mark, length); min_mark is reset to all-ones at each MEASURE entry.
REQ-019 When the SAMPLE_MARKS-th accepted mark ends, on the next clk edge: dit_time=min_mark, dah_time=3*dit, word_time=7*dit, tol_time=dit>>1; locked=1; state=LOCKED.
REQ-020 Products SHALL be computed at `PULSE_CNT_W+3 bits.
REQ-021 If any product exceeds `PULSE_CNT_W bits, all four outputs SHALL keep their old values, cal_error SHALL pulse, and the state SHALL go to WAIT_LOW.
REQ-022 All four outputs SHALL change on the same clk edge; no mixed old/new set is ever visible.
REQ-023 During WAIT_LOW and MEASURE, the outputs SHALL hold their last values so decoding continues uninterrupted.
REQ-024 recal=1 in any state SHALL clear locked and the counts and enter WAIT_LOW on the next edge; the outputs are held.
REQ-025 recal coinciding with the final mark SHALL take priority: no update, no lock.
REQ-026 IDLE SHALL be entered only from LOCKED when the signal stays low for 255 ce ticks; IDLE behaves as LOCKED, and a rising signal returns it to LOCKED.
REQ-027 With ce=0, state, counters and sampled signal SHALL hold; recal and rst still act.

Reset
REQ-028 rst SHALL override all inputs, including recal.
REQ-029 On rst: dit_time=DEFAULT_DIT, dah_time=3*DEFAULT_DIT, word_time=7*DEFAULT_DIT, tol_time=DEFAULT_DIT>>1, locked=0, cal_error=0, counts cleared, state WAIT_LOW.
REQ-030 rst asserted mid-MEASURE SHALL discard partial measurements.

Configuration
REQ-031 Macro MORSE_CAL_MANUAL_EN defined SHALL add inputs use_manual (1 bit) and manual_dit (`PULSE_CNT_W bits).
REQ-032 With MORSE_CAL_MANUAL_EN defined and use_manual=1: outputs derive from manual_dit each cycle per REQ-019/020/021, locked=1, measurement is frozen in WAIT_LOW, and recal is ignored.
REQ-033 With MORSE_CAL_MANUAL_EN undefined, these ports and this logic SHALL be absent and behaviour is as above.

Verification
REQ-034 rst, then release -> dit=10, dah=30, word=70, tol=5, locked=0 on the first cycle after release.
REQ-035 ce every cycle; 8 marks of lengths 4,12,4,4,12,4,12,4 separated by 4-tick gaps -> one edge after the last falling edge: dit=4, dah=12, word=28, tol=2, locked=1.
REQ-036 1-tick glitch marks interleaved with 8 marks of 6 ticks -> dit=6; glitches are not counted.
REQ-037 signal held high until the counter saturates -> cal_error one-cycle pulse, outputs unchanged, state WAIT_LOW.
REQ-038 recal on the same cycle as the 8th falling edge -> locked stays 0, outputs unchanged, recalibration restarts.
REQ-039 MORSE_CAL_MANUAL_EN defined, use_manual=1, manual_dit=5 -> dit=5, dah=15, word=35, tol=2, locked=1; marks are ignored.
